prbs_lock_checker: RTL and testbench

- Receive-side checker for the parallel PN (PRBS) words produced by the team's combinational parallel PN generator.
- Sits downstream of the serializer/loopback path. It self-synchronises to the incoming DW-bit stream, then free-runs ("flywheels") its own expected sequence.
- Reports per-word errors and keeps saturating bit, word and error-word counters for link bring-up and loop detection.

---
 rtl/prbs_pkg.sv | 27 ++
 rtl/prbs_lock_checker_pngen.sv | 25 ++
 rtl/prbs_lock_checker.sv | 169 ++++++++++++++++
 tb/tb_prbs_lock_checker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared constants, FSM state encoding and helpers for the PRBS lock checker.
package prbs_pkg;

    localparam int          POL_W_DEF      = 7;
    localparam logic [7:0]  POL_MASK_DEF   = 8'hC0;
    localparam int          DW_DEF         = 16;
    localparam int          LOCK_CNT_DEF   = 4;
    localparam int          UNLOCK_CNT_DEF = 4;
    localparam int          CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Words up to 64 bits; callers zero-extend and truncate the result.
    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs_lock_checker_pngen.sv
// Combinational parallel PN generator: one DW-bit word per call, MSB generated first.
module prbs_lock_checker_pngen
    import prbs_pkg::*;
#(
    parameter int               POL_W    = POL_W_DEF,
    parameter logic [POL_W:0]   POL_MASK = POL_MASK_DEF,
    parameter int               DW       = DW_DEF
) (
    input  logic [POL_W-1:0] pn_state_in,
    output logic [DW-1:0]    pn_generated,
    output logic [POL_W-1:0] pn_state_out
);

    // Bits are resolved top-down so each tap window only reads bits already computed.
    always_comb begin : gen
        logic [POL_W+DW-1:0] full;
        full = {pn_state_in, {DW{1'b0}}};
        for (int i = DW - 1; i >= 0; i--) begin
            full[i] = ^(full[i +: POL_W+1] & POL_MASK);
        end
        pn_generated = full[DW-1:0];
        pn_state_out = full[POL_W-1:0];
    end

endmodule

// File: rtl/prbs_lock_checker.sv
// PRBS receive checker: self-synchronises to the incoming stream, then flywheels
// its own sequence and keeps saturating bit/word/error-word counters.
module prbs_lock_checker
    import prbs_pkg::*;
#(
    parameter int               POL_W      = POL_W_DEF,
    parameter logic [POL_W:0]   POL_MASK   = POL_MASK_DEF,
    parameter int               DW         = DW_DEF,
    parameter int               LOCK_CNT   = LOCK_CNT_DEF,
    parameter int               UNLOCK_CNT = UNLOCK_CNT_DEF,
    parameter int               CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             locked,
    output logic             err_valid,
    output logic             err_word,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic [CNT_W-1:0] word_err_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic             cnt_sat
);

    localparam int GC_W  = $clog2(LOCK_CNT + 1);
    localparam int BC_W  = $clog2(UNLOCK_CNT + 1);
    localparam int PC_W  = $clog2(DW + 1);
    localparam int SUM_W = ((CNT_W >= PC_W) ? CNT_W : PC_W) + 1;

    state_e           r_state, w_state_nxt;
    logic [POL_W-1:0] r_seed, w_seed_nxt;
    logic [GC_W-1:0]  r_good_cnt, w_good_nxt, w_good_inc;
    logic [BC_W-1:0]  r_bad_cnt, w_bad_nxt, w_bad_inc;
    logic             r_locked, r_err_valid, r_err_word, r_cnt_sat;
    logic [CNT_W-1:0] r_bit_err_cnt, r_word_err_cnt, r_word_cnt;

    logic [DW-1:0]    w_exp, w_diff;
    logic [POL_W-1:0] w_seed_adv, w_slice;
    logic             w_slice_nz, w_match, w_check;
    logic [PC_W-1:0]  w_pop;
    logic [SUM_W-1:0] w_bit_sum, w_werr_sum, w_word_sum;
    logic             w_bit_ovf, w_werr_ovf, w_word_ovf;

    prbs_lock_checker_pngen #(
        .POL_W    (POL_W),
        .POL_MASK (POL_MASK),
        .DW       (DW)
    ) u_pngen (
        .pn_state_in  (r_seed),
        .pn_generated (w_exp),
        .pn_state_out (w_seed_adv)
    );

    assign w_slice    = in_data[POL_W-1:0];
    assign w_slice_nz = |w_slice;
    assign w_diff     = in_data ^ w_exp;
    assign w_match    = ~|w_diff;
    assign w_check    = in_valid && (r_state == LOCKED);
    assign w_good_inc = r_good_cnt + GC_W'(1);
    assign w_bad_inc  = r_bad_cnt + BC_W'(1);

    // NOTE: every always_comb output gets a hold value first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_seed_nxt  = r_seed;
        w_good_nxt  = r_good_cnt;
        w_bad_nxt   = r_bad_cnt;
        if (in_valid) begin
            unique case (r_state)
                HUNT: begin
                    if (w_slice_nz) begin
                        w_seed_nxt  = w_slice;
                        w_good_nxt  = '0;
                        w_state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    if (w_match) begin
                        w_seed_nxt = w_slice;
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == GC_W'(LOCK_CNT)) begin
                            w_state_nxt = LOCKED;
                            w_bad_nxt   = '0;
                        end
                    end else if (w_slice_nz) begin
                        w_seed_nxt = w_slice;
                        w_good_nxt = '0;
                    end else begin
                        w_state_nxt = HUNT;
                    end
                end
                LOCKED: begin
                    // Flywheel: the line data never reseeds, so one hit costs one word.
                    w_seed_nxt = w_seed_adv;
                    if (w_match) begin
                        w_bad_nxt = '0;
                    end else begin
                        w_bad_nxt = w_bad_inc;
                        if (w_bad_inc == BC_W'(UNLOCK_CNT)) begin
                            w_state_nxt = HUNT;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HUNT;
            r_seed     <= '0;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_seed     <= w_seed_nxt;
            r_good_cnt <= w_good_nxt;
            r_bad_cnt  <= w_bad_nxt;
            r_locked   <= (w_state_nxt == LOCKED);
        end
    end

    assign w_pop      = PC_W'(popcount(64'(w_diff)));
    assign w_bit_sum  = SUM_W'(r_bit_err_cnt) + SUM_W'(w_pop);
    assign w_werr_sum = SUM_W'(r_word_err_cnt) + SUM_W'(!w_match);
    assign w_word_sum = SUM_W'(r_word_cnt) + SUM_W'(1);
    assign w_bit_ovf  = |w_bit_sum[SUM_W-1:CNT_W];
    assign w_werr_ovf = |w_werr_sum[SUM_W-1:CNT_W];
    assign w_word_ovf = |w_word_sum[SUM_W-1:CNT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_valid    <= 1'b0;
            r_err_word     <= 1'b0;
            r_bit_err_cnt  <= '0;
            r_word_err_cnt <= '0;
            r_word_cnt     <= '0;
            r_cnt_sat      <= 1'b0;
        end else begin
            r_err_valid <= w_check;
            r_err_word  <= w_check && !w_match;
            if (clear) begin
                r_bit_err_cnt  <= '0;
                r_word_err_cnt <= '0;
                r_word_cnt     <= '0;
                r_cnt_sat      <= 1'b0;
            end else if (w_check) begin
                r_bit_err_cnt  <= w_bit_ovf  ? '1 : w_bit_sum[CNT_W-1:0];
                r_word_err_cnt <= w_werr_ovf ? '1 : w_werr_sum[CNT_W-1:0];
                r_word_cnt     <= w_word_ovf ? '1 : w_word_sum[CNT_W-1:0];
                r_cnt_sat      <= r_cnt_sat | w_bit_ovf | w_werr_ovf | w_word_ovf;
            end
        end
    end

    assign locked       = r_locked;
    assign err_valid    = r_err_valid;
    assign err_word     = r_err_word;
    assign bit_err_cnt  = r_bit_err_cnt;
    assign word_err_cnt = r_word_err_cnt;
    assign word_cnt     = r_word_cnt;
    assign cnt_sat      = r_cnt_sat;

endmodule

// File: tb/tb_prbs_lock_checker.sv
// Directed, table-driven bench for prbs_lock_checker with a serial PRBS7 reference model.
module tb_prbs_lock_checker;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;

    logic        locked, err_valid, err_word, cnt_sat;
    logic [15:0] bit_err_cnt, word_err_cnt, word_cnt;

    logic        s_locked, s_err_valid, s_err_word, s_cnt_sat;
    logic [3:0]  s_bit_err_cnt, s_word_err_cnt, s_word_cnt;

    int checks   = 0;
    int failures = 0;

    logic [6:0]  tb_seed;

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        exp_locked;
        logic        exp_err_valid;
        logic        exp_err_word;
    } vec_t;

    vec_t vecs[64];

    prbs_lock_checker u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .locked       (locked),
        .err_valid    (err_valid),
        .err_word     (err_word),
        .bit_err_cnt  (bit_err_cnt),
        .word_err_cnt (word_err_cnt),
        .word_cnt     (word_cnt),
        .cnt_sat      (cnt_sat)
    );

    prbs_lock_checker #(
        .CNT_W      (4),
        .UNLOCK_CNT (100)
    ) u_dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .locked       (s_locked),
        .err_valid    (s_err_valid),
        .err_word     (s_err_word),
        .bit_err_cnt  (s_bit_err_cnt),
        .word_err_cnt (s_word_err_cnt),
        .word_cnt     (s_word_cnt),
        .cnt_sat      (s_cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial x^7+x^6+1 LFSR, first bit shifted out lands in the word MSB.
    function automatic logic [15:0] gen_word(input logic [6:0] s_in);
        logic [6:0]  s;
        logic [15:0] w;
        logic        b;
        s = s_in;
        w = '0;
        for (int k = 0; k < 16; k++) begin
            b = s[6] ^ s[5];
            s = {s[5:0], b};
            w = {w[14:0], b};
        end
        return w;
    endfunction

    task automatic next_word(output logic [15:0] w);
        w = gen_word(tb_seed);
        tb_seed = w[6:0];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic c);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_main_cnt(input string tag, input int wc, input int bc, input int wec);
        check({tag, " word_cnt"},     32'(word_cnt),     32'(wc));
        check({tag, " bit_err_cnt"},  32'(bit_err_cnt),  32'(bc));
        check({tag, " word_err_cnt"}, 32'(word_err_cnt), 32'(wec));
    endtask

    initial begin
        logic [15:0] w;
        logic        v;

        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        tb_seed  = 7'h7F;

        for (int i = 0; i < 64; i++) begin
            next_word(w);
            vecs[i].valid = 1'b1;
            if (i == 45)
                vecs[i].data = w ^ 16'h0008;
            else if (i >= 50 && i <= 53)
                vecs[i].data = ~w;
            else
                vecs[i].data = w;
            vecs[i].exp_locked    = (i >= 4 && i <= 52) || (i >= 58);
            vecs[i].exp_err_valid = (i >= 5 && i <= 53) || (i >= 59);
            vecs[i].exp_err_word  = (i == 45) || (i >= 50 && i <= 53);
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst locked",       32'(locked),       32'd0);
        check("rst err_valid",    32'(err_valid),    32'd0);
        check("rst err_word",     32'(err_word),     32'd0);
        check_main_cnt("rst", 0, 0, 0);
        check("rst cnt_sat",      32'(cnt_sat),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lock acquisition, single-bit hit, 4-word burst to unlock, relock.
        for (int i = 0; i < 64; i++) begin
            step(vecs[i].valid, vecs[i].data, 1'b0);
            check($sformatf("vec%0d locked", i),    32'(locked),    32'(vecs[i].exp_locked));
            check($sformatf("vec%0d err_valid", i), 32'(err_valid), 32'(vecs[i].exp_err_valid));
            check($sformatf("vec%0d err_word", i),  32'(err_word),  32'(vecs[i].exp_err_word));
            if (i == 39) check_main_cnt("clean40", 35, 0, 0);
            if (i == 49) check_main_cnt("bitflip", 45, 1, 1);
            if (i == 63) check_main_cnt("burst", 54, 65, 5);
        end

        // Gapped stream: idle cycles carry garbage that must be ignored.
        for (int k = 0; k < 10; k++) begin
            v = (k % 2 == 0);
            if (v) next_word(w);
            else   w = 16'hA5A5;
            step(v, w, 1'b0);
            check($sformatf("gap%0d err_valid", k), 32'(err_valid), 32'(v));
            check($sformatf("gap%0d err_word", k),  32'(err_word),  32'd0);
        end
        check_main_cnt("gap", 59, 65, 5);
        check("gap locked", 32'(locked), 32'd1);

        // Clear wins over the same-cycle increment; lock is untouched.
        next_word(w);
        step(1'b1, w, 1'b1);
        check_main_cnt("clear", 0, 0, 0);
        check("clear cnt_sat",   32'(cnt_sat),   32'd0);
        check("clear locked",    32'(locked),    32'd1);
        check("clear err_valid", 32'(err_valid), 32'd1);
        next_word(w);
        step(1'b1, w, 1'b0);
        check("post-clear word_cnt", 32'(word_cnt), 32'd1);

        // Asynchronous reset mid-lock, observed before the next clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst locked",    32'(locked),    32'd0);
        check("async rst err_valid", 32'(err_valid), 32'd0);
        check("async rst word_cnt",  32'(word_cnt),  32'd0);
        check("async rst s_locked",  32'(s_locked),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero stream is the lock-up state and must never be accepted.
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 16'h0000, 1'b0);
            check($sformatf("zero%0d locked", k),    32'(locked),    32'd0);
            check($sformatf("zero%0d err_valid", k), 32'(err_valid), 32'd0);
        end
        check("zero word_cnt", 32'(word_cnt), 32'd0);

        for (int j = 0; j < 5; j++) begin
            next_word(w);
            step(1'b1, w, 1'b0);
            check($sformatf("relock%0d locked", j),   32'(locked),   32'(j == 4));
            check($sformatf("relock%0d s_locked", j), 32'(s_locked), 32'(j == 4));
        end
        step(1'b0, 16'h0000, 1'b1);
        check("sat pre word_cnt", 32'(s_word_cnt), 32'd0);

        // Narrow counters: one fully inverted word already clamps the bit counter.
        for (int j = 0; j < 20; j++) begin
            next_word(w);
            step(1'b1, ~w, 1'b0);
            if (j == 0) begin
                check("sat first bit_err_cnt",  32'(s_bit_err_cnt),  32'd15);
                check("sat first word_err_cnt", 32'(s_word_err_cnt), 32'd1);
                check("sat first cnt_sat",      32'(s_cnt_sat),      32'd1);
            end
        end
        check("sat bit_err_cnt",  32'(s_bit_err_cnt),  32'd15);
        check("sat word_err_cnt", 32'(s_word_err_cnt), 32'd15);
        check("sat word_cnt",     32'(s_word_cnt),     32'd15);
        check("sat cnt_sat",      32'(s_cnt_sat),      32'd1);
        check("sat locked",       32'(s_locked),       32'd1);

        step(1'b0, 16'h0000, 1'b1);
        check("sat clr bit_err_cnt",  32'(s_bit_err_cnt),  32'd0);
        check("sat clr word_err_cnt", 32'(s_word_err_cnt), 32'd0);
        check("sat clr word_cnt",     32'(s_word_cnt),     32'd0);
        check("sat clr cnt_sat",      32'(s_cnt_sat),      32'd0);
        check("sat clr locked",       32'(s_locked),       32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
